// File: rtl/ffo_scanner.sv
// ffo_scanner: accepts a word, then streams the index of every set bit, lowest index first.
// Defining FFO_SCANNER_COUNT_EN adds out_count, the popcount of the accepted word.
module ffo_scanner #(
    parameter int WIDTH = 32,
    localparam int PW = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:WIDTH-1] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:PW-1]   out_pos,
    output logic            out_last,
    output logic            out_zero
`ifdef FFO_SCANNER_COUNT_EN
    ,
    output logic [PW:0]     out_count
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state, state_next;
    logic [0:WIDTH-1]  mask, mask_next;
    logic              zero_q, zero_next;

    logic              tval [0:PW][0:WIDTH-1];
    logic [PW-1:0]     tpos [0:PW][0:WIDTH-1];
    logic [PW-1:0]     enc_pos;
    logic              any;
    logic              single;

    // Pairwise merge tree: a valid left half wins, otherwise the right half's
    // position is taken with the bit for this level set.
    always_comb begin
        for (int l = 0; l <= PW; l++) begin
            for (int n = 0; n < WIDTH; n++) begin
                tval[l][n] = 1'b0;
                tpos[l][n] = '0;
            end
        end
        for (int n = 0; n < WIDTH; n++) begin
            tval[0][n] = mask[n];
        end
        for (int l = 0; l < PW; l++) begin
            for (int n = 0; n < (WIDTH >> (l + 1)); n++) begin
                tval[l+1][n] = tval[l][2*n] | tval[l][2*n+1];
                tpos[l+1][n] = tval[l][2*n] ? tpos[l][2*n]
                                            : (tpos[l][2*n+1] | (PW'(1) << l));
            end
        end
    end

    assign enc_pos = tpos[PW][0];
    assign any     = tval[PW][0];
    assign single  = ((mask & (mask - WIDTH'(1))) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mask   <= '0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_next;
            mask   <= mask_next;
            zero_q <= zero_next;
        end
    end

    // A zero word still yields one result: no bits pending counts as "last".
    always_comb begin
        state_next = state;
        mask_next  = mask;
        zero_next  = zero_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_pos    = '0;
        out_last   = 1'b0;
        out_zero   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mask_next  = in_data;
                    zero_next  = (in_data == '0);
                    state_next = SCAN;
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                out_pos   = any ? enc_pos : '0;
                out_last  = single;
                out_zero  = zero_q;
                if (out_ready) begin
                    if (single) begin
                        state_next = IDLE;
                    end else begin
                        mask_next[enc_pos] = 1'b0;
                    end
                end
            end
        endcase
    end

`ifdef FFO_SCANNER_COUNT_EN
    logic [PW:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{PW{1'b0}}, in_data[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_count <= '0;
        end else if (state == IDLE && in_valid) begin
            out_count <= pop;
        end
    end
`endif

endmodule

// File: doc/ffo_scanner.md
FFO_SCANNER -- requirements
Module: ffo_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning scanned word width; legal values are powers of two, 4 to 256.
REQ-002 SHALL have derived localparam PW = $clog2(WIDTH), meaning position field width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a word is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-007 SHALL have port in_data, input, [0:WIDTH-1], meaning the word to scan; index 0 has the highest priority.
REQ-008 SHALL have port out_valid, output, 1, meaning a position result is presented.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 SHALL have port out_pos, output, [0:PW-1], meaning the lowest index of a set bit still pending.
REQ-011 SHALL have port out_last, output, 1, meaning this is the final result for the current word.
REQ-012 SHALL have port out_zero, output, 1, meaning the accepted word was all zeros.

Function
REQ-013 SHALL implement FSM states IDLE and SCAN, plus a WIDTH-bit pending-mask register.
REQ-014 SHALL drive in_ready=1 only in IDLE; an input transfer occurs when in_valid && in_ready.
REQ-015 SHALL, on an input transfer, load the mask with in_data and move to SCAN; out_valid rises on the next cycle (1-cycle latency).
REQ-016 SHALL, in SCAN, drive out_valid=1, out_pos = lowest set index of the mask, and out_last=1 when the mask has at most one set bit.
REQ-017 SHALL, for a zero word, emit exactly one result with out_zero=1, out_pos=0 and out_last=1.
REQ-018 SHALL, on an output transfer (out_valid && out_ready) with out_last=0, clear the mask bit at out_pos and stay in SCAN.
REQ-019 SHALL, on an output transfer with out_last=1, return to IDLE; the next word can be accepted one cycle later (one bubble per word).
REQ-020 SHALL hold out_pos, out_last and out_zero stable while out_valid=1 and out_ready=0.
REQ-021 SHALL emit the positions of a word with k set bits in strictly ascending index order, as exactly k results (1 result when k=0).
REQ-022 SHALL compute the priority encode with a log2(WIDTH)-level tree of valid/position pairs (pairwise merge: left valid selects left, else right with MSB set).
REQ-023 SHALL NOT change the mask when in_valid is asserted during SCAN; that offered word is not accepted.
REQ-024 SHALL hold out_zero constant for all results of a word.

Reset
REQ-025 SHALL, when reset is high at a clock edge, enter IDLE and clear the mask; a word that is mid-scan is discarded without further results.
REQ-026 SHALL output, after reset: in_ready=1, out_valid=0, out_pos=0, out_last=0, out_zero=0.
REQ-027 SHALL ignore in_valid and out_ready in any cycle where reset is high.

Configuration
REQ-028 SHALL, when macro FFO_SCANNER_COUNT_EN is defined, add output out_count [PW:0], holding the number of set bits in the accepted word; it is registered at acceptance, stable for all results of that word, and 0 after reset.
REQ-029 SHALL, without FFO_SCANNER_COUNT_EN, have no out_count port and no popcount logic; all other behaviour is identical.

Verification (WIDTH=32)
REQ-030 SHALL cover: in_data=32'h8000_0001, out_ready=1 -> results pos 0 (last=0) then pos 31 (last=1); in_ready=1 again in the cycle after the final result.
REQ-031 SHALL cover: in_data=0 -> exactly one result, out_zero=1, pos=0, last=1; with COUNT_EN, out_count=0.
REQ-032 SHALL cover: in_data=32'hFFFF_FFFF with out_ready toggling 1/0 -> 32 results, pos 0..31 ascending, outputs held during stalls; with COUNT_EN, out_count=32.
REQ-033 SHALL cover: in_data=32'h0010_0400 accepted, reset pulsed after the first result (pos 11) -> next cycle out_valid=0 and in_ready=1; a following word 32'h0000_0002 yields only pos 30.
REQ-034 SHALL cover: in_valid held high with a new word during SCAN -> the word is not accepted until IDLE, and the current word's results are unaffected.
REQ-035 SHALL cover: WIDTH=8, in_data=8'b0100_0100 -> pos 1 then pos 5 (last=1), out_pos 3 bits wide.
